// File: rtl/uart_cmd_decoder_pkg.sv
// Shared opcodes, response constants and parser state encoding for uart_cmd_decoder.
package uart_cmd_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RESP_ERR  = 8'hEE;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GET_ADDR  = 3'd1,
    GET_DATA  = 3'd2,
    SEND_RESP = 3'd3,
    WAIT_TX   = 3'd4
  } state_e;

endpackage

// File: rtl/uart_cmd_decoder_if.sv
// UART-side byte handshake: receiver byte strobe in, transmitter request/status.
interface uart_cmd_decoder_if;
  logic       i_Rx_DV;
  logic [7:0] i_Rx_Byte;
  logic       i_Tx_Active;
  logic       i_Tx_Done;
  logic       o_Tx_DV;
  logic [7:0] o_Tx_Byte;

  modport master (
    output i_Rx_DV, i_Rx_Byte, i_Tx_Active, i_Tx_Done,
    input  o_Tx_DV, o_Tx_Byte
  );

  modport slave (
    input  i_Rx_DV, i_Rx_Byte, i_Tx_Active, i_Tx_Done,
    output o_Tx_DV, o_Tx_Byte
  );
endinterface

// File: rtl/uart_cmd_decoder_regfile.sv
// NUM_REGS x 8 register file: one synchronous write port, one combinational read port.
module uart_cmd_regfile #(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned AW       = 3
) (
  input  logic                  i_Clock,
  input  logic                  i_Rst_L,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [7:0]            wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [7:0]            rd_data,
  output logic [8*NUM_REGS-1:0] regs_flat
);

  logic [7:0] regs_q [NUM_REGS];
  logic [7:0] regs_d [NUM_REGS];

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[wr_addr] = wr_data;
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) regs_q <= '{default: '0};
    else          regs_q <= regs_d;
  end

  // Non-power-of-two depths leave unused index codes; they read as zero.
  always_comb begin
    rd_data = (32'(rd_addr) < NUM_REGS) ? regs_q[rd_addr] : '0;
  end

  always_comb begin
    regs_flat = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) regs_flat[8*i +: 8] = regs_q[i];
  end

endmodule

// File: rtl/uart_cmd_decoder.sv
// UART byte command parser ('W' addr data / 'R' addr) with register file and error counter.
// Optional inter-byte timeout is built when CMD_TIMEOUT_EN is defined.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int unsigned NUM_REGS     = 8,
  parameter int unsigned TIMEOUT_CLKS = 1200
) (
  input  logic                  i_Clock,
  input  logic                  i_Rst_L,
  uart_cmd_decoder_if.slave     bus,
  output logic [8*NUM_REGS-1:0] o_Regs,
  output logic [7:0]            o_Err_Count,
  output logic                  o_Busy
);

  localparam int unsigned AW = $clog2(NUM_REGS);

  if (NUM_REGS < 2 || NUM_REGS > 256 || TIMEOUT_CLKS < 2) begin : g_bad_params
    $error("uart_cmd_decoder: illegal NUM_REGS or TIMEOUT_CLKS");
  end

  state_e        state_q, state_d, eff_state;
  logic          is_wr_q, is_wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          addr_err_q, addr_err_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic          err_evt, reg_we, tmo_hit, rx_oor;
  logic [7:0]    rd_data;

  assign rx_oor = 32'(bus.i_Rx_Byte) >= NUM_REGS;

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CLKS + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          in_cmd;

  assign in_cmd  = (state_q == GET_ADDR) || (state_q == GET_DATA);
  assign tmo_hit = in_cmd && (tmo_cnt_q == TW'(TIMEOUT_CLKS - 1));

  always_comb begin
    tmo_cnt_d = '0;
    if (in_cmd && !tmo_hit && !bus.i_Rx_DV) tmo_cnt_d = tmo_cnt_q + 1'b1;
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) tmo_cnt_q <= '0;
    else          tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  uart_cmd_regfile #(.NUM_REGS(NUM_REGS), .AW(AW)) u_regfile (
    .i_Clock  (i_Clock),
    .i_Rst_L  (i_Rst_L),
    .wr_en    (reg_we),
    .wr_addr  (addr_q),
    .wr_data  (bus.i_Rx_Byte),
    .rd_addr  (bus.i_Rx_Byte[AW-1:0]),
    .rd_data  (rd_data),
    .regs_flat(o_Regs)
  );

  // A timeout aborts the command and the same cycle's byte is parsed as if in IDLE;
  // the response byte is latched with the address so it is stable before o_Tx_DV.
  always_comb begin
    eff_state   = tmo_hit ? IDLE : state_q;
    state_d     = eff_state;
    is_wr_d     = is_wr_q;
    addr_d      = addr_q;
    addr_err_d  = addr_err_q;
    tx_byte_d   = tx_byte_q;
    err_evt     = tmo_hit;
    reg_we      = 1'b0;
    bus.o_Tx_DV = 1'b0;

    case (eff_state)
      IDLE: begin
        if (bus.i_Rx_DV) begin
          if (bus.i_Rx_Byte == CMD_WRITE || bus.i_Rx_Byte == CMD_READ) begin
            is_wr_d = (bus.i_Rx_Byte == CMD_WRITE);
            state_d = GET_ADDR;
          end else begin
            err_evt = 1'b1;
          end
        end
      end
      GET_ADDR: begin
        if (bus.i_Rx_DV) begin
          addr_d     = bus.i_Rx_Byte[AW-1:0];
          addr_err_d = rx_oor;
          if (rx_oor) err_evt = 1'b1;
          if (is_wr_q) begin
            state_d = GET_DATA;
          end else begin
            tx_byte_d = rx_oor ? RESP_ERR : rd_data;
            state_d   = SEND_RESP;
          end
        end
      end
      GET_DATA: begin
        if (bus.i_Rx_DV) begin
          reg_we  = !addr_err_q;
          state_d = IDLE;
        end
      end
      SEND_RESP: begin
        if (bus.i_Rx_DV) err_evt = 1'b1;
        if (!bus.i_Tx_Active) begin
          bus.o_Tx_DV = 1'b1;
          state_d     = WAIT_TX;
        end
      end
      WAIT_TX: begin
        if (bus.i_Rx_DV) err_evt = 1'b1;
        if (bus.i_Tx_Done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    err_cnt_d = (err_evt && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      state_q    <= IDLE;
      is_wr_q    <= 1'b0;
      addr_q     <= '0;
      addr_err_q <= 1'b0;
      tx_byte_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      is_wr_q    <= is_wr_d;
      addr_q     <= addr_d;
      addr_err_q <= addr_err_d;
      tx_byte_q  <= tx_byte_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign bus.o_Tx_Byte = tx_byte_q;
  assign o_Err_Count   = err_cnt_q;
  assign o_Busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: directed vector table, corner sequences,
// and random command streams checked against a queue-based command model.
module tb_uart_cmd_decoder;
  import uart_cmd_pkg::*;

  localparam int unsigned NREG = 8;
  localparam int unsigned TMO  = 50;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;

  uart_cmd_decoder_if ifc();
  logic [8*NREG-1:0] regs;
  logic [7:0]        err;
  logic              busy;
  logic              tx_hold = 1'b0;
  logic              tx_xmit = 1'b0;

  assign ifc.i_Tx_Active = tx_hold | tx_xmit;

  uart_cmd_decoder #(.NUM_REGS(NREG), .TIMEOUT_CLKS(TMO)) dut (
    .i_Clock    (clk),
    .i_Rst_L    (rst_l),
    .bus        (ifc),
    .o_Regs     (regs),
    .o_Err_Count(err),
    .o_Busy     (busy)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] rsp_q[$];
  logic [7:0] m_regs[NREG];
  int         m_err;
  logic [7:0] pend[$];
  logic [7:0] exp_rsp[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: accumulate bytes of the current command, act when it is complete.
  task automatic m_byte(input logic [7:0] b);
    pend.push_back(b);
    if (pend[0] != CMD_WRITE && pend[0] != CMD_READ) begin
      if (m_err < 255) m_err++;
      pend.delete();
    end else if (pend.size() == 2) begin
      if (pend[1] >= NREG && m_err < 255) m_err++;
      if (pend[0] == CMD_READ) begin
        exp_rsp.push_back(pend[1] < NREG ? m_regs[pend[1]] : RESP_ERR);
        pend.delete();
      end
    end else if (pend.size() == 3) begin
      if (pend[1] < NREG) m_regs[pend[1]] = pend[2];
      pend.delete();
    end
  endtask

  function automatic logic [63:0] m_flat();
    logic [63:0] f = '0;
    for (int i = 0; i < NREG; i++) f[8*i +: 8] = m_regs[i];
    return f;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    ifc.i_Rx_DV   = 1'b1;
    ifc.i_Rx_Byte = b;
    @(posedge clk);
    #1;
    ifc.i_Rx_DV   = 1'b0;
    ifc.i_Rx_Byte = 8'($urandom);
  endtask

  task automatic rnd_send(input logic [7:0] b);
    repeat ($urandom_range(0, 4)) @(posedge clk);
    m_byte(b);
    send_byte(b);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_l = 1'b0;
    ifc.i_Rx_DV = 1'b0;
    @(negedge clk);
    rst_l = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || tx_xmit || ifc.i_Tx_Done) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_idle_wait"}, 64'(n >= 300), 64'd0);
  endtask

  task automatic pop_rsp(input string name, input logic [7:0] exp);
    chk({name, "_rsp_count"}, 64'(rsp_q.size()), 64'd1);
    if (rsp_q.size() > 0) chk({name, "_rsp"}, 64'(rsp_q.pop_front()), 64'(exp));
  endtask

  // Transmitter model: accepts a request, stays active a few cycles, then pulses done.
  initial begin
    logic [7:0] b;
    ifc.i_Tx_Done = 1'b0;
    forever begin
      @(negedge clk);
      if (ifc.o_Tx_DV === 1'b1) begin
        b = ifc.o_Tx_Byte;
        rsp_q.push_back(b);
        @(posedge clk);
        #1;
        tx_xmit = 1'b1;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        chk("tx_byte_hold", 64'(ifc.o_Tx_Byte), 64'(b));
        ifc.i_Tx_Done = 1'b1;
        @(negedge clk);
        ifc.i_Tx_Done = 1'b0;
        tx_xmit = 1'b0;
      end
    end
  end

  initial begin
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      if (ifc.o_Tx_DV === 1'b1) chk("tx_dv_single", 64'(prev), 64'd0);
      prev = ifc.o_Tx_DV;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [23:0] bytes;
    int unsigned n;
    logic [7:0]  exp_err;
    bit          is_rd;
    logic [7:0]  exp_rsp;
    logic [63:0] exp_regs;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [7:0] b;
    tbl[0] = '{24'h5703A5, 3, 8'd0, 1'b0, 8'h00, 64'h00000000_A5000000};
    tbl[1] = '{24'h520300, 2, 8'd0, 1'b1, 8'hA5, 64'h00000000_A5000000};
    tbl[2] = '{24'h410000, 1, 8'd1, 1'b0, 8'h00, 64'h00000000_A5000000};
    tbl[3] = '{24'h520900, 2, 8'd2, 1'b1, 8'hEE, 64'h00000000_A5000000};
    tbl[4] = '{24'h57073C, 3, 8'd2, 1'b0, 8'h00, 64'h3C000000_A5000000};
    tbl[5] = '{24'h570811, 3, 8'd3, 1'b0, 8'h00, 64'h3C000000_A5000000};
    tbl[6] = '{24'h520700, 2, 8'd3, 1'b1, 8'h3C, 64'h3C000000_A5000000};
    tbl[7] = '{24'h520000, 2, 8'd3, 1'b1, 8'h00, 64'h3C000000_A5000000};

    ifc.i_Rx_DV   = 1'b0;
    ifc.i_Rx_Byte = 8'h00;
    do_reset();
    chk("reset_regs", regs, 64'd0);
    chk("reset_err", 64'(err), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_tx_dv", 64'(ifc.o_Tx_DV), 64'd0);
    chk("reset_tx_byte", 64'(ifc.o_Tx_Byte), 64'd0);

    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < int'(tbl[i].n); k++) begin
        b = tbl[i].bytes[23-8*k -: 8];
        send_byte(b);
      end
      chk($sformatf("vec%0d_regs", i), regs, tbl[i].exp_regs);
      if (tbl[i].is_rd) chk($sformatf("vec%0d_tx_dv", i), 64'(ifc.o_Tx_DV), 64'd1);
      wait_idle($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_err", i), 64'(err), 64'(tbl[i].exp_err));
      chk($sformatf("vec%0d_busy", i), 64'(busy), 64'd0);
      if (tbl[i].is_rd) pop_rsp($sformatf("vec%0d", i), tbl[i].exp_rsp);
    end

    // Read while the transmitter is busy: request must wait for i_Tx_Active low.
    begin
      logic seen = 1'b0;
      tx_hold = 1'b1;
      send_byte(CMD_READ);
      send_byte(8'h03);
      repeat (20) begin
        @(negedge clk);
        if (ifc.o_Tx_DV) seen = 1'b1;
      end
      chk("hold_no_dv", 64'(seen), 64'd0);
      chk("hold_busy", 64'(busy), 64'd1);
      @(posedge clk);
      #1;
      tx_hold = 1'b0;
      #1;
      chk("hold_release_dv", 64'(ifc.o_Tx_DV), 64'd1);
      wait_idle("hold");
      pop_rsp("hold", 8'hA5);
      chk("hold_err", 64'(err), 64'd3);
    end

    // Byte arriving during the response is dropped and counted.
    send_byte(CMD_READ);
    send_byte(8'h03);
    send_byte(CMD_WRITE);
    wait_idle("drop");
    chk("drop_err", 64'(err), 64'd4);
    pop_rsp("drop", 8'hA5);
    send_byte(8'h01);
    chk("drop_followup_err", 64'(err), 64'd5);
    chk("drop_busy", 64'(busy), 64'd0);

    // Reset in GET_DATA aborts the command.
    send_byte(CMD_WRITE);
    send_byte(8'h02);
    chk("mid_busy", 64'(busy), 64'd1);
    do_reset();
    chk("mid_rst_regs", regs, 64'd0);
    chk("mid_rst_err", 64'(err), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_tx_dv", 64'(ifc.o_Tx_DV), 64'd0);
    chk("mid_rst_tx_byte", 64'(ifc.o_Tx_Byte), 64'd0);
    send_byte(8'hA5);
    chk("mid_after_err", 64'(err), 64'd1);
    chk("mid_after_regs", regs, 64'd0);

    // Saturation.
    do_reset();
    for (int i = 0; i < 254; i++) send_byte(8'h00);
    chk("sat_fe", 64'(err), 64'hFE);
    for (int i = 0; i < 46; i++) send_byte(8'h00);
    chk("sat_ff", 64'(err), 64'hFF);

    // Partial command followed by a long silence.
    do_reset();
    send_byte(CMD_WRITE);
    send_byte(8'h01);
    repeat (60) @(negedge clk);
`ifdef CMD_TIMEOUT_EN
    chk("tmo_busy", 64'(busy), 64'd0);
    chk("tmo_err", 64'(err), 64'd1);
    send_byte(8'h77);
    chk("tmo_after_err", 64'(err), 64'd2);
    chk("tmo_regs", regs, 64'd0);
    chk("tmo_after_busy", 64'(busy), 64'd0);
    // A byte in the expiry cycle is parsed as a fresh opcode.
    do_reset();
    send_byte(CMD_READ);
    repeat (TMO - 1) @(posedge clk);
    send_byte(CMD_WRITE);
    send_byte(8'h05);
    send_byte(8'h66);
    chk("tmo_edge_regs", regs, 64'h00006600_00000000);
    chk("tmo_edge_err", 64'(err), 64'd1);
`else
    chk("notmo_busy", 64'(busy), 64'd1);
    chk("notmo_err", 64'(err), 64'd0);
    send_byte(8'h77);
    chk("notmo_regs", regs, 64'h00000000_00007700);
    chk("notmo_err2", 64'(err), 64'd0);
    chk("notmo_after_busy", 64'(busy), 64'd0);
`endif

    // Random command streams against the model.
    do_reset();
    for (int i = 0; i < NREG; i++) m_regs[i] = 8'h00;
    m_err = 0;
    pend.delete();
    exp_rsp.delete();
    rsp_q.delete();
    for (int it = 0; it < 150; it++) begin
      int unsigned kind;
      logic [7:0] op, a, d;
      kind = $urandom_range(0, 9);
      if (kind < 2) begin
        do op = 8'($urandom); while (op == CMD_WRITE || op == CMD_READ);
        rnd_send(op);
      end else if (kind < 6) begin
        a = 8'($urandom_range(0, 11));
        d = 8'($urandom);
        rnd_send(CMD_WRITE);
        rnd_send(a);
        rnd_send(d);
      end else begin
        a = 8'($urandom_range(0, 11));
        rnd_send(CMD_READ);
        rnd_send(a);
      end
      wait_idle("rnd");
      chk("rnd_err", 64'(err), 64'(m_err));
      chk("rnd_regs", regs, m_flat());
      while (exp_rsp.size() > 0) begin
        d = exp_rsp.pop_front();
        pop_rsp("rnd", d);
      end
    end
    chk("rnd_rsp_leftover", 64'(rsp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_cmd_decoder.md
# uart_cmd_decoder

Byte-level command decoder sitting directly downstream of the UART receiver. It consumes the receiver's one-cycle byte-valid pulses, parses 'W' (write) and 'R' (read) commands into a small register file, and emits read-response bytes to the UART transmitter. Its register outputs drive the project's configuration and control logic.

## Interface
- NUM_REGS, 8: number of 8-bit registers; legal values are 2 to 256.
- TIMEOUT_CLKS, 1200: maximum number of idle clocks allowed between bytes of one command.
- i_Clock  in  1  system clock; all logic is on the rising edge.
- i_Rst_L  in  1  reset; one clock; reset is synchronous and active-low.
- i_Rx_DV  in  1  one-cycle pulse; i_Rx_Byte is valid in that cycle.
- i_Rx_Byte  in  8  received byte.
- i_Tx_Active  in  1  high while the transmitter is sending.
- i_Tx_Done  in  1  one-cycle pulse when the transmitter finishes a byte.
- o_Tx_DV  out  1  one-cycle request to send o_Tx_Byte.
- o_Tx_Byte  out  8  response byte; held stable from the o_Tx_DV cycle until i_Tx_Done.
- o_Regs  out  8*NUM_REGS  flattened register file; register n occupies bits [8n+7:8n].
- o_Err_Count  out  8  saturating error counter (stops at 0xFF).
- o_Busy  out  1  high in every state except IDLE.

## Operation
- Commands:
  - Write: 0x57 ('W'), then an address byte, then a data byte.
  - Read: 0x52 ('R'), then an address byte. The decoder answers with one byte.
- States and transitions:
  - IDLE: a valid byte of 0x57 or 0x52 goes to GET_ADDR and latches the opcode. Any other byte is discarded and increments the error count. The decoder stays in IDLE.
  - GET_ADDR: the next valid byte is latched as the address.
    - For a write, go to GET_DATA.
    - For a read, go to SEND_RESP.
    - An address >= NUM_REGS increments the error count. A write still goes to GET_DATA.
  - GET_DATA: the next valid byte is written to reg[addr], then go to IDLE. If the address was out of range, no write occurs.
  - SEND_RESP: wait until i_Tx_Active is low. Then pulse o_Tx_DV for one cycle with o_Tx_Byte = reg[addr], or 0xEE if the address was out of range. Go to WAIT_TX.
  - WAIT_TX: on i_Tx_Done, go to IDLE.
- Bytes that arrive in SEND_RESP or WAIT_TX are dropped and increment the error count.
- Only one error increment happens per cycle. The counter saturates at 0xFF.

## Timing
- Reset values:
  - all o_Regs bits 0; o_Tx_DV 0; o_Tx_Byte 0x00; o_Err_Count 0; o_Busy 0.
  - State returns to IDLE and the timeout counter is cleared.
- Reset in the middle of a command aborts it with no partial write. A response already handed to the transmitter is not recalled.
- Write latency: the new value is visible on o_Regs in the cycle after the data byte's i_Rx_DV cycle.
- Read latency: o_Tx_DV is high in the cycle after the address byte's i_Rx_DV cycle, provided i_Tx_Active is low then. Otherwise it is delayed until the first cycle with i_Tx_Active low.
- o_Tx_DV is never high for two consecutive cycles.
- A write followed immediately by a read of the same address returns the new value.
- i_Tx_Done is ignored outside WAIT_TX.
- i_Rx_DV arriving in the same cycle as the timeout expiry: the timeout wins, and the byte is re-evaluated as if in IDLE.

## Configuration
- CMD_TIMEOUT_EN defined:
  - In GET_ADDR and GET_DATA, a counter of width $clog2(TIMEOUT_CLKS+1) clears on every i_Rx_DV.
  - When it reaches TIMEOUT_CLKS-1 with no new byte, the decoder returns to IDLE, increments the error count and performs no write.
- CMD_TIMEOUT_EN undefined:
  - No counter is built.
  - A partial command waits indefinitely for its next byte.

## Structure
- Package uart_cmd_pkg holds:
  - opcode constants CMD_WRITE = 8'h57 and CMD_READ = 8'h52;
  - the error response byte RESP_ERR = 8'hEE;
  - the 3-bit state encoding: IDLE, GET_ADDR, GET_DATA, SEND_RESP, WAIT_TX.
- Sub-module uart_cmd_regfile provides:
  - NUM_REGS x 8 storage with synchronous reset;
  - a single write port (enable, address, data);
  - a combinational read port and the flattened o_Regs output.
- The parser FSM, timeout counter and error counter live in the top level.

## Test plan
- Write: send 0x57, 0x03, 0xA5 -> o_Regs[31:24] = 0xA5 one cycle after the third DV; all other registers stay 0; o_Err_Count = 0.
- Read back: after the write above, send 0x52, 0x03 -> o_Tx_DV is pulsed once with o_Tx_Byte = 0xA5. Hold i_Tx_Active high for 20 cycles first -> o_Tx_DV waits until i_Tx_Active falls.
- Bad input:
  - send 0x41 -> o_Err_Count = 1 and state stays IDLE;
  - send 0x52, 0x09 with NUM_REGS = 8 -> response 0xEE and o_Err_Count = 2.
- Timeout (CMD_TIMEOUT_EN defined, TIMEOUT_CLKS = 50): send 0x57, 0x01, then nothing for 60 cycles, then 0x77 -> no write occurs, o_Err_Count = 2 (timeout plus the bad 0x77 opcode), o_Busy is low.
- Reset and saturation:
  - assert i_Rst_L low while in GET_DATA -> all outputs return to their reset values;
  - send 300 bad opcodes -> o_Err_Count = 0xFF.
